regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the bits per register.
REQ-003 The block SHALL have parameter REG_COUNT, default 32, giving the register count; it SHALL be a power of two and at least 4.
REQ-004 The block SHALL have parameter NUM_RD, default 2, giving the read port count (1..8).
REQ-005 The block SHALL have parameter NUM_WR, default 2, giving the write port count (1..4).
REQ-006 The block SHALL have localparam ADDR_WIDTH equal to $clog2(REG_COUNT).
REQ-007 The block SHALL have port clk_i, input, 1 bit: the clock, rising edge.
REQ-008 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-009 The block SHALL have port clr_i, input, 1 bit: single-cycle request to start a full clear.
REQ-010 The block SHALL have port we_i, input, NUM_WR bits: per-port write enable.
REQ-011 The block SHALL have port waddr_i, input, NUM_WR x ADDR_WIDTH: write addresses.
REQ-012 The block SHALL have port wdata_i, input, NUM_WR x DATA_WIDTH: write data.
REQ-013 The block SHALL have port raddr_i, input, NUM_RD x ADDR_WIDTH: read addresses.
REQ-014 The block SHALL have port rdata_o, output, NUM_RD x DATA_WIDTH: read data, combinational from raddr_i.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high while a clear sequence is running.

Function
REQ-016 Register 0 SHALL always read 0; writes to address 0 SHALL be dropped on every port.
REQ-017 A write SHALL take effect on the rising edge at which we_i[k] is high, with the state in IDLE and waddr_i[k] != 0.
REQ-018 When several ports write the same address in one cycle, the highest-index port SHALL win; the other ports' writes to that address SHALL be discarded.
REQ-019 Writes to distinct addresses in the same cycle SHALL all commit.
REQ-020 The FSM SHALL have two states, CLEAR and IDLE, with a clear counter clr_cnt of ADDR_WIDTH bits.
REQ-021 In IDLE, clr_i = 1 SHALL set clr_cnt to 1 and move the FSM to CLEAR on the next edge.
REQ-022 In CLEAR, each cycle SHALL write 0 to rx[clr_cnt] and increment clr_cnt.
REQ-023 The FSM SHALL return to IDLE after the edge that clears address REG_COUNT-1, so a clear takes exactly REG_COUNT-1 cycles.
REQ-024 In CLEAR, every we_i SHALL be ignored, clr_i SHALL be ignored, and all rdata_o SHALL read 0.
REQ-025 busy_o SHALL equal (state == CLEAR), driven from a register with no combinational input path.

Reset
REQ-026 While rst_i is high at an edge, the FSM SHALL enter CLEAR with clr_cnt = 1, so busy_o = 1 in the cycle after reset.
REQ-027 The register array SHALL have no reset of its own; it SHALL be zeroed only by the CLEAR sequence.
REQ-028 rst_i asserted mid-clear SHALL restart the sequence from address 1.
REQ-029 rdata_o SHALL read 0 from the first cycle after reset until the clear sequence completes.

Configuration
REQ-030 With macro REGFILE_MP_BYPASS_EN defined, a read in IDLE whose address matches a valid same-cycle write SHALL return the winning wdata_i (per REQ-018) combinationally.
REQ-031 Without REGFILE_MP_BYPASS_EN, such a read SHALL return the pre-edge stored value; the new value SHALL be visible from the next cycle.

Structure
REQ-032 register_file_pkg SHALL hold the default DATA_WIDTH and REG_COUNT constants and the FSM state typedef (CLEAR, IDLE).
REQ-033 Sub-module regfile_mp_wr_arb SHALL resolve per-address write priority and bypass selection; the array and FSM SHALL stay in regfile_mp.

Verification
REQ-034 Reset, then hold rst_i = 0 -> busy_o = 1 for exactly REG_COUNT-1 = 31 cycles; afterwards all 32 addresses read 0x00000000.
REQ-035 In IDLE, port 0 writes addr 5 = 0xDEADBEEF and port 1 writes addr 5 = 0x12345678 in the same cycle -> the next cycle addr 5 reads 0x12345678.
REQ-036 Write addr 0 = 0xFFFFFFFF on both ports -> raddr 0 reads 0 on all read ports.
REQ-037 Write addr 7 = 0xA5A5A5A5 while raddr_i[1] = 7 in the same cycle -> with REGFILE_MP_BYPASS_EN, rdata_o[1] = 0xA5A5A5A5 in that cycle; without it, rdata_o[1] = 0 in that cycle and 0xA5A5A5A5 the next cycle.
REQ-038 Fill addr 1..31 with nonzero data, pulse clr_i, and issue a write to addr 3 during CLEAR -> busy_o = 1 for 31 cycles, the write is dropped, and all addresses read 0 afterwards.
REQ-039 Assert rst_i at clear cycle 10 -> the sequence restarts and busy_o stays high for 31 further cycles after reset is released.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants and FSM state type for the multi-port register file.
package register_file_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_COUNT  = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_t;
endpackage

// File: rtl/regfile_mp_wr_arb.sv
// Write-port arbitration and read-side selection for regfile_mp.
// Collapses the write ports into one enable/value per register, with the
// highest-index port winning. It also forms the read value from the stored
// word, masking address 0 to zero.
// Optional feature: REGFILE_MP_BYPASS_EN forwards a same-cycle winning write
// to any read of the same address.
module regfile_mp_wr_arb import register_file_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic [NUM_WR-1:0]                  we,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]  waddr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]  wdata,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]  raddr,
  input  logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_stored,
  output logic [REG_COUNT-1:0]               wen,
  output logic [REG_COUNT-1:0][DATA_WIDTH-1:0] wval,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_val
);

  // Per-register write decode; ascending port order lets the last port win.
  always_comb begin
    wen  = '0;
    wval = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (waddr[k] != '0)) begin
        wen[waddr[k]]  = 1'b1;
        wval[waddr[k]] = wdata[k];
      end
    end
  end

  // Read selection: address 0 is hard zero; optional forwarding of the winning write.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (raddr[r] == '0) begin
        rd_val[r] = '0;
      end else begin
`ifdef REGFILE_MP_BYPASS_EN
        rd_val[r] = wen[raddr[r]] ? wval[raddr[r]] : rd_stored[r];
`else
        rd_val[r] = rd_stored[r];
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a hard-zero register 0. After reset or a
// clr_i pulse, a CLEAR sequence zeroes registers 1..REG_COUNT-1, one per cycle.
// Writes are ignored and reads return 0 while the clear runs.
// Optional feature: REGFILE_MP_BYPASS_EN (write-to-read forwarding, in regfile_mp_wr_arb).
module regfile_mp import register_file_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clr_i,
  input  logic [NUM_WR-1:0]                  we_i,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic                               busy_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

  rf_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   rx [REG_COUNT];

  logic [NUM_WR-1:0]                    we_idle;
  logic [REG_COUNT-1:0]                 wen;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] wval;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_stored, rd_val;

  // Write ports only count in IDLE; the arbiter never sees CLEAR-time writes.
  assign we_idle = (state_q == IDLE) ? we_i : '0;

  regfile_mp_wr_arb #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR)
  ) u_wr_arb (
    .we        (we_idle),
    .waddr     (waddr_i),
    .wdata     (wdata_i),
    .raddr     (raddr_i),
    .rd_stored (rd_stored),
    .wen       (wen),
    .wval      (wval),
    .rd_val    (rd_val)
  );

  // FSM state and clear counter; reset starts a fresh clear from address 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= ADDR_WIDTH'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: clr_i starts a clear from IDLE; CLEAR walks to the last address.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d   = CLEAR;
          clr_cnt_d = ADDR_WIDTH'(1);
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = ADDR_WIDTH'(1);
      end
    endcase
  end

  // Register array, no reset: zeroed by CLEAR, otherwise takes arbitrated writes.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      rx[clr_cnt_q] <= '0;
    end else if (!rst_i) begin
      for (int i = 0; i < REG_COUNT; i++)
        if (wen[i]) rx[i] <= wval[i];
    end
  end

  // Read ports: stored word through the arbiter, forced to zero outside IDLE.
  always_comb begin
    rd_stored = '0;
    rdata_o   = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_stored[r] = rx[raddr_i[r]];
      rdata_o[r]   = (state_q == IDLE) ? rd_val[r] : '0;
    end
  end

  assign busy_o = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters). Read expectations
// come from a reference model and pass through a queue; they are compared
// when the DUT's read data is sampled.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int RC = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b0;
  logic                   clr_i = 1'b0;
  logic [NW-1:0]          we_i = '0;
  logic [NW-1:0][AW-1:0]  waddr_i = '0;
  logic [NW-1:0][DW-1:0]  wdata_i = '0;
  logic [NR-1:0][AW-1:0]  raddr_i = '0;
  logic [NR-1:0][DW-1:0]  rdata_o;
  logic                   busy_o;

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] mdl [RC];
  logic [DW-1:0] exp_q [$];

  regfile_mp u_dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .raddr_i (raddr_i),
    .rdata_o (rdata_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Point every read port at addr; expect the model value on each.
  task automatic read_chk(input string tag, input logic [AW-1:0] a);
    for (int r = 0; r < NR; r++) begin
      raddr_i[r] = a;
      exp_q.push_back(mdl[a]);
    end
    #1;
    for (int r = 0; r < NR; r++) chk(tag, rdata_o[r], exp_q.pop_front());
  endtask

  // One write cycle in IDLE; the model applies ports in ascending order.
  task automatic wr(input logic [NW-1:0] we, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we_i = we;
    waddr_i[0] = a0; wdata_i[0] = d0;
    waddr_i[1] = a1; wdata_i[1] = d1;
    step();
    if (we[0] && a0 != 0) mdl[a0] = d0;
    if (we[1] && a1 != 0) mdl[a1] = d1;
    we_i = '0;
  endtask

  // Count busy cycles (bounded), checking reads stay zero during the clear.
  task automatic count_busy(input string tag, input bit poke_wr);
    int n;
    n = 0;
    while (busy_o && n < 100) begin
      if (poke_wr && n == 2) begin
        we_i = 2'b01; waddr_i[0] = 5'd3; wdata_i[0] = 32'hBADC0DE0;
      end else begin
        we_i = '0;
      end
      if (n == 0 || n == 15) begin
        raddr_i[0] = 5'd3; raddr_i[1] = 5'd31;
        #1;
        chk({tag, "_rd0"}, rdata_o[0], 32'h0);
        chk({tag, "_rd1"}, rdata_o[1], 32'h0);
      end
      step();
      n++;
    end
    we_i = '0;
    chk({tag, "_busy_cycles"}, DW'(n), DW'(RC - 1));
    for (int i = 0; i < RC; i++) mdl[i] = '0;
  endtask

  initial begin
    logic [DW-1:0] byp_exp;
    for (int i = 0; i < RC; i++) mdl[i] = '0;

    // Reset, then the power-up clear.
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    chk("rst_busy", DW'(busy_o), 32'h1);
    count_busy("rst", 1'b0);
    chk("idle_busy", DW'(busy_o), 32'h0);
    for (int a = 0; a < RC; a++) read_chk("post_rst_zero", AW'(a));

    // Same-address collision: highest port wins.
    wr(2'b11, 5'd5, 32'hDEADBEEF, 5'd5, 32'h12345678);
    read_chk("collide_a5", 5'd5);

    // Writes to address 0 are dropped.
    wr(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
    read_chk("addr0_zero", 5'd0);

    // Same-cycle write/read of addr 7.
    raddr_i[1] = 5'd7;
    we_i = 2'b01; waddr_i[0] = 5'd7; wdata_i[0] = 32'hA5A5A5A5;
`ifdef REGFILE_MP_BYPASS_EN
    byp_exp = 32'hA5A5A5A5;
`else
    byp_exp = mdl[7];
`endif
    exp_q.push_back(byp_exp);
    #1;
    chk("same_cycle_a7", rdata_o[1], exp_q.pop_front());
    step();
    mdl[7] = 32'hA5A5A5A5;
    we_i = '0;
    read_chk("next_cycle_a7", 5'd7);

    // Distinct-address pairs and random traffic against the model.
    wr(2'b11, 5'd9, 32'h11112222, 5'd10, 32'h33334444);
    read_chk("distinct_a9", 5'd9);
    read_chk("distinct_a10", 5'd10);
    for (int t = 0; t < 24; t++) begin
      wr(NW'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), $urandom(),
         AW'($urandom_range(0, 7)), $urandom());
      read_chk("rand", AW'($urandom_range(0, 7)));
    end

    // Fill 1..31, then clr_i with a write poked during CLEAR.
    for (int a = 1; a < RC; a += 2)
      wr(2'b11, AW'(a), 32'hC0DE0000 | a, AW'((a + 1) % RC), 32'hC0DE0000 | ((a + 1) % RC));
    read_chk("fill_a3", 5'd3);
    read_chk("fill_a31", 5'd31);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("clr_busy", DW'(busy_o), 32'h1);
    count_busy("clr", 1'b1);
    for (int a = 0; a < RC; a++) read_chk("post_clr_zero", AW'(a));

    // Reset mid-clear restarts the sequence.
    for (int a = 1; a < RC; a += 2)
      wr(2'b11, AW'(a), 32'h5A000000 | a, AW'((a + 1) % RC), 32'h5A000000 | ((a + 1) % RC));
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("midrst_busy", DW'(busy_o), 32'h1);
    count_busy("midrst", 1'b0);
    for (int a = 0; a < RC; a++) read_chk("post_midrst_zero", AW'(a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
